// File: rtl/tetrix_pkg.sv
// Shared types for the Tetrix keyboard path: command codes, PS/2 scan codes,
// parser states and the scan-code to command key map.
package tetrix_pkg;

  localparam int unsigned CMD_W    = 3;
  localparam int unsigned NUM_CMDS = 7;
  localparam int unsigned SC_W     = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5,
    CMD_PAUSE     = 3'd6,
    CMD_RESTART   = 3'd7
  } cmd_e;

  localparam logic [SC_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [SC_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [SC_W-1:0] SC_A     = 8'h1C;
  localparam logic [SC_W-1:0] SC_D     = 8'h23;
  localparam logic [SC_W-1:0] SC_W_KEY = 8'h1D;
  localparam logic [SC_W-1:0] SC_S     = 8'h1B;
  localparam logic [SC_W-1:0] SC_SPACE = 8'h29;
  localparam logic [SC_W-1:0] SC_P     = 8'h4D;
  localparam logic [SC_W-1:0] SC_ESC   = 8'h76;
  localparam logic [SC_W-1:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [SC_W-1:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [SC_W-1:0] SC_ARROW_UP    = 8'h75;
  localparam logic [SC_W-1:0] SC_ARROW_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parse_state_e;

  // Extended codes and normal codes live in separate maps; unmapped gives CMD_NONE.
  function automatic cmd_e map_key(input logic ext, input logic [SC_W-1:0] code);
    cmd_e key;
    key = CMD_NONE;
    if (ext) begin
      case (code)
        SC_ARROW_LEFT:  key = CMD_LEFT;
        SC_ARROW_RIGHT: key = CMD_RIGHT;
        SC_ARROW_UP:    key = CMD_ROTATE;
        SC_ARROW_DOWN:  key = CMD_SOFT_DROP;
        default:        key = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_A:     key = CMD_LEFT;
        SC_D:     key = CMD_RIGHT;
        SC_W_KEY: key = CMD_ROTATE;
        SC_S:     key = CMD_SOFT_DROP;
        SC_SPACE: key = CMD_HARD_DROP;
        SC_P:     key = CMD_PAUSE;
        SC_ESC:   key = CMD_RESTART;
        default:  key = CMD_NONE;
      endcase
    end
    return key;
  endfunction

endpackage

// File: rtl/keyboard_command_decoder_if.sv
// Scan-code input and command output bundle between the keyboard receiver,
// the decoder and the game controller.
interface keyboard_command_decoder_if;
  import tetrix_pkg::*;

  logic [SC_W-1:0]     scanCode;
  logic                scanValid;
  logic [CMD_W-1:0]    cmd;
  logic                cmdValid;
  logic                cmdReady;
  logic [NUM_CMDS-1:0] held;
  logic                overflow;

  modport master (
    output scanCode, scanValid, cmdReady,
    input  cmd, cmdValid, held, overflow
  );

  modport slave (
    input  scanCode, scanValid, cmdReady,
    output cmd, cmdValid, held, overflow
  );

endinterface

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with a registered head word (zero when empty);
// simultaneous push and pop are honoured even when full.
module cmd_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             pop_ok_c;
  logic             push_ok_c;
  logic             overflow_c;
  logic [PTR_W-1:0] rd_next_c;
  logic [CNT_W-1:0] count_next_c;
  logic [WIDTH-1:0] head_next_c;

  // Next-cycle occupancy and head word, so dout/full/empty can be registered.
  always_comb begin
    pop_ok_c     = pop && !empty;
    push_ok_c    = push && (!full || pop_ok_c);
    overflow_c   = push && full && !pop_ok_c;
    rd_next_c    = pop_ok_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    if (count_next_c == '0)
      head_next_c = '0;
    else if (push_ok_c && count_next_c == CNT_W'(1))
      head_next_c = din;
    else
      head_next_c = mem[rd_next_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout     <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_next_c;
      count    <= count_next_c;
      dout     <= head_next_c;
      full     <= (count_next_c == CNT_W'(DEPTH));
      empty    <= (count_next_c == '0);
      overflow <= overflow_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keyboard_command_decoder.sv
// Turns PS/2 make/break/extended byte sequences into Tetrix commands,
// tracks held keys to suppress typematic repeat, and queues commands.
module keyboard_command_decoder
  import tetrix_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                       clk,
  input logic                       rst,
  keyboard_command_decoder_if.slave bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  parse_state_e        state;
  parse_state_e        state_next_c;
  logic [TO_W-1:0]     to_cnt;
  logic [NUM_CMDS-1:0] held;

  logic                ext_c;
  logic                make_c;
  logic                brk_c;
  cmd_e                key_c;
  logic                key_hit_c;
  logic [NUM_CMDS-1:0] key_mask_c;
  logic                push_c;
  logic                pop_c;
  logic                fifo_empty;
  logic                fifo_full_unused;

  // Sequence parser: classify the incoming byte and pick the next state.
  always_comb begin
    state_next_c = state;
    ext_c        = 1'b0;
    make_c       = 1'b0;
    brk_c        = 1'b0;
    if (bus.scanValid) begin
      if (bus.scanCode == SC_EXT) begin
        state_next_c = ST_EXT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.scanCode == SC_BREAK) state_next_c = ST_BRK;
            else make_c = 1'b1;
          end
          ST_EXT: begin
            if (bus.scanCode == SC_BREAK) begin
              state_next_c = ST_EXT_BRK;
            end else begin
              ext_c        = 1'b1;
              make_c       = 1'b1;
              state_next_c = ST_IDLE;
            end
          end
          ST_BRK: begin
            brk_c        = 1'b1;
            state_next_c = ST_IDLE;
          end
          ST_EXT_BRK: begin
            ext_c        = 1'b1;
            brk_c        = 1'b1;
            state_next_c = ST_IDLE;
          end
          default: state_next_c = ST_IDLE;
        endcase
      end
    end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_next_c = ST_IDLE;
    end

    key_c      = map_key(ext_c, bus.scanCode);
    key_hit_c  = (key_c != CMD_NONE);
    key_mask_c = key_hit_c ? (NUM_CMDS'(1) << (key_c - CMD_W'(1))) : '0;
    push_c     = make_c && key_hit_c && ((held & key_mask_c) == '0);
  end

  // State, idle timeout and held bitmap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
      held   <= '0;
    end else begin
      state <= state_next_c;
      if (bus.scanValid || state_next_c == ST_IDLE) to_cnt <= '0;
      else to_cnt <= to_cnt + TO_W'(1);
      if (make_c) held <= held | key_mask_c;
      else if (brk_c) held <= held & ~key_mask_c;
    end
  end

  assign pop_c = bus.cmdReady && !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_c),
    .din      (key_c),
    .pop      (pop_c),
    .dout     (bus.cmd),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .overflow (bus.overflow)
  );

  assign bus.cmdValid = !fifo_empty;
  assign bus.held     = held;

endmodule

// File: tb/tb_keyboard_command_decoder.sv
// Directed self-checking bench for keyboard_command_decoder.
module tb_keyboard_command_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  keyboard_command_decoder_if bus ();

  keyboard_command_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte is presented for exactly one rising edge; returns on the following falling edge.
  task automatic send(input logic [7:0] b);
    bus.scanCode  = b;
    bus.scanValid = 1'b1;
    @(negedge clk);
    bus.scanValid = 1'b0;
  endtask

  task automatic pop_one();
    bus.cmdReady = 1'b1;
    @(negedge clk);
    bus.cmdReady = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] cmd_e_v,
                               input logic valid_e, input logic [7:0] held_e);
    check({tag, ".cmd"},      8'(bus.cmd),      cmd_e_v);
    check({tag, ".cmdValid"}, 8'(bus.cmdValid), 8'(valid_e));
    check({tag, ".held"},     8'(bus.held),     held_e);
  endtask

  logic [7:0] fill_keys [4];

  initial begin
    errors = 0;
    checks = 0;
    fill_keys[0] = 8'h1C;
    fill_keys[1] = 8'h23;
    fill_keys[2] = 8'h1D;
    fill_keys[3] = 8'h1B;

    rst           = 1'b1;
    bus.scanCode  = 8'h00;
    bus.scanValid = 1'b0;
    bus.cmdReady  = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset", 8'h0, 1'b0, 8'h00);
    check("reset.overflow", 8'(bus.overflow), 8'h0);
    rst = 1'b0;
    @(negedge clk);

    // Make, typematic repeat, break of A
    send(8'h1C);
    check_outputs("make_a", 8'h1, 1'b1, 8'h01);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    check_outputs("brk_a", 8'h1, 1'b1, 8'h00);
    pop_one();
    check_outputs("single_a", 8'h0, 1'b0, 8'h00);

    // Extended up arrow make and break
    send(8'hE0);
    send(8'h75);
    check_outputs("ext_up", 8'h3, 1'b1, 8'h04);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_outputs("ext_up_brk", 8'h3, 1'b1, 8'h00);
    pop_one();
    check("ext_up_single", 8'(bus.cmdValid), 8'h0);

    // Extended left arrow
    send(8'hE0);
    send(8'h6B);
    check_outputs("ext_left", 8'h1, 1'b1, 8'h01);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("ext_left_brk.held", 8'(bus.held), 8'h00);
    pop_one();

    // Prefix abandoned after idle timeout: 74 is then an unmapped normal make
    send(8'hE0);
    repeat (TO + 4) @(negedge clk);
    send(8'h74);
    check_outputs("timeout", 8'h0, 1'b0, 8'h00);

    // Fill the FIFO, then overflow on the fifth distinct make
    for (int i = 0; i < 4; i++) begin
      send(fill_keys[i]);
      send(8'hF0);
      send(fill_keys[i]);
    end
    check_outputs("full", 8'h1, 1'b1, 8'h00);
    check("full.overflow", 8'(bus.overflow), 8'h0);
    send(8'h29);
    check("ovf.pulse", 8'(bus.overflow), 8'h1);
    @(negedge clk);
    check("ovf.once", 8'(bus.overflow), 8'h0);
    send(8'hF0);
    send(8'h29);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 8'(bus.cmd), 8'(i + 1));
      pop_one();
    end
    check_outputs("drained", 8'h0, 1'b0, 8'h00);

    // Full FIFO with pop and push in the same cycle
    for (int i = 0; i < 4; i++) begin
      send(fill_keys[i]);
      send(8'hF0);
      send(fill_keys[i]);
    end
    bus.cmdReady  = 1'b1;
    bus.scanCode  = 8'h4D;
    bus.scanValid = 1'b1;
    @(negedge clk);
    bus.cmdReady  = 1'b0;
    bus.scanValid = 1'b0;
    check("pp.overflow", 8'(bus.overflow), 8'h0);
    check_outputs("pp", 8'h2, 1'b1, 8'h20);
    begin
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h2;
      exp_q[1] = 8'h3;
      exp_q[2] = 8'h4;
      exp_q[3] = 8'h6;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("pp_drain%0d", i), 8'(bus.cmd), exp_q[i]);
        pop_one();
      end
    end
    check("pp_drained", 8'(bus.cmdValid), 8'h0);
    send(8'hF0);
    send(8'h4D);
    check("pp_release.held", 8'(bus.held), 8'h00);

    // Reset mid-sequence discards break prefix, FIFO and held; same-cycle byte ignored
    send(8'h23);
    check_outputs("pre_rst", 8'h2, 1'b1, 8'h02);
    send(8'hF0);
    rst           = 1'b1;
    bus.scanCode  = 8'h1C;
    bus.scanValid = 1'b1;
    @(negedge clk);
    check_outputs("in_rst", 8'h0, 1'b0, 8'h00);
    check("in_rst.overflow", 8'(bus.overflow), 8'h0);
    rst           = 1'b0;
    bus.scanValid = 1'b0;
    send(8'h29);
    check_outputs("post_rst", 8'h5, 1'b1, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
